// File: rtl/pe_drain_pkg.sv
// Shared types, widths and the requantization helper for the PE column drain.
// Pure declarations, no timing of its own.
// Requant widths are fixed here; the top only exposes FIFO depth.
package pe_drain_pkg;

  localparam int INT_BW         = 5;
  localparam int FRA_BW         = 7;
  localparam int MUL_BW         = 16;
  localparam int ACC_BW         = 32;
  localparam int CNT_BW         = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Output range in Q(INT_BW.FRA_BW) units, held at ACC_BW+1 bits to match the rounding sum.
  localparam logic signed [ACC_BW:0] SAT_MAX =
    $signed({{(ACC_BW + 1 - INT_BW - FRA_BW){1'b0}}, {(INT_BW + FRA_BW){1'b1}}});
  localparam logic signed [ACC_BW:0] SAT_MIN =
    $signed({{(ACC_BW + 1 - INT_BW - FRA_BW){1'b1}}, {(INT_BW + FRA_BW){1'b0}}});
  // Half an output LSB, expressed in input fraction bits.
  localparam logic signed [ACC_BW:0] RND_HALF =
    $signed({{(ACC_BW + 1 - FRA_BW){1'b0}}, 1'b1, {(FRA_BW - 1){1'b0}}});

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    FLUSH
  } state_e;

  typedef struct packed {
    logic              sat;
    logic [MUL_BW-1:0] q;
  } rq_t;

  // Round half up, drop FRA_BW fraction bits, clamp to the output range.
  // One extra bit of headroom keeps acc near +max from wrapping when the half is added.
  function automatic rq_t requant(input logic [ACC_BW-1:0] acc);
    logic signed [ACC_BW:0] wide;
    logic signed [ACC_BW:0] shr;
    rq_t                    r;
    wide  = $signed({acc[ACC_BW-1], acc}) + RND_HALF;
    shr   = wide >>> FRA_BW;
    r.sat = 1'b0;
    r.q   = shr[MUL_BW-1:0];
    if (shr > SAT_MAX) begin
      r.q   = SAT_MAX[MUL_BW-1:0];
      r.sat = 1'b1;
    end else if (shr < SAT_MIN) begin
      r.q   = SAT_MIN[MUL_BW-1:0];
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_col_drain_if.sv
// Output stream of the column drain: requantized word with valid/ready.
// No storage; pure wiring.
// Producer holds dout_o stable while dout_valid_o is high and not accepted.
interface pe_col_drain_if;
  import pe_drain_pkg::*;

  logic signed [MUL_BW-1:0] dout_o;
  logic                     dout_valid_o;
  logic                     dout_ready_i;

  modport master (output dout_o, output dout_valid_o, input dout_ready_i);
  modport slave  (input dout_o, input dout_valid_o, output dout_ready_i);

endinterface

// File: rtl/drain_fifo.sv
// Synchronous FIFO; the head is read from storage, never bypassed from the write port.
// Latency: a word written on an edge is visible on dat_o from the next cycle.
// Push while full is taken only together with a pop; push_ok_o reports acceptance.
module drain_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dat_o,
  output logic                       push_ok_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop;

  // Status, acceptance and pointer advance; the extra pointer MSB separates full from empty.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop    = pop_i && !empty_o;
    push_ok_o = push_i && (!full_o || do_pop);
    wr_ptr_d  = wr_ptr_q + (AW + 1)'(push_ok_o);
    rd_ptr_d  = rd_ptr_q + (AW + 1)'(do_pop);
    cnt_o     = wr_ptr_q - rd_ptr_q;
    dat_o     = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointers and storage; a full push+pop overwrites the slot being popped this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
    end
  end

endmodule

// File: rtl/pe_col_drain.sv
// Drains one PE column: after a skew captures len accumulators, requantizes and streams them.
// Latency: capture edge -> quant reg -> FIFO write next edge -> dout_valid_o the cycle after.
// Never stalls the array: pushes to a full FIFO without a same-cycle pop are dropped, ovf_o sticks.
module pe_col_drain
  import pe_drain_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [CNT_BW-1:0]  len_i,
  input  logic [CNT_BW-1:0]  skew_i,
  input  logic [ACC_BW-1:0]  acc_i,
  pe_col_drain_if.master     dout_if,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_BW-1:0]  sat_cnt_o,
  output logic               ovf_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [CNT_BW-1:0]   skew_cnt_q, skew_cnt_d;
  logic [CNT_BW-1:0]   len_cnt_q, len_cnt_d;
  logic [CNT_BW-1:0]   sat_cnt_q, sat_cnt_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                q_vld_q, q_vld_d;
  logic [MUL_BW-1:0]   q_dat_q, q_dat_d;
  rq_t                 rq;

  logic                fifo_push_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         fifo_cnt;
  logic                pop;
  logic                drain_done;

  assign dout_if.dout_valid_o = ~fifo_empty;
  assign pop = dout_if.dout_valid_o & dout_if.dout_ready_i;

  // Tile ends when nothing is left in the quant stage and the last FIFO word leaves this cycle,
  // so done_o lands one cycle after the final pop (or two cycles after start for len=0).
  assign drain_done = (state_q == FLUSH) && !q_vld_q &&
                      (fifo_empty || ((fifo_cnt == (AW + 1)'(1)) && pop));

  drain_fifo #(
    .W     (MUL_BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (q_vld_q),
    .dat_i     (q_dat_q),
    .pop_i     (pop),
    .dat_o     (dout_if.dout_o),
    .push_ok_o (fifo_push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .cnt_o     (fifo_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: skew and len counters count down to 1 so each phase lasts exactly its count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0)       state_d = FLUSH;
          else if (skew_i == '0) state_d = CAPTURE;
          else                   state_d = WAIT;
        end
      end
      WAIT:    if (skew_cnt_q == CNT_BW'(1)) state_d = CAPTURE;
      CAPTURE: if (len_cnt_q == CNT_BW'(1))  state_d = FLUSH;
      FLUSH:   if (drain_done)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath and status updates; start_i is only looked at in IDLE.
  always_comb begin
    skew_cnt_d = skew_cnt_q;
    len_cnt_d  = len_cnt_q;
    sat_cnt_d  = sat_cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    q_vld_d    = 1'b0;
    q_dat_d    = q_dat_q;
    rq         = requant(acc_i);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          skew_cnt_d = skew_i;
          len_cnt_d  = len_i;
          sat_cnt_d  = '0;
          ovf_d      = 1'b0;
        end
      end
      WAIT: skew_cnt_d = skew_cnt_q - CNT_BW'(1);
      CAPTURE: begin
        len_cnt_d = len_cnt_q - CNT_BW'(1);
        q_vld_d   = 1'b1;
        q_dat_d   = rq.q;
        if (rq.sat && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + CNT_BW'(1);
      end
      FLUSH:   done_d = drain_done;
      default: ;
    endcase
    if (q_vld_q && !fifo_push_ok) ovf_d = 1'b1;
  end

  // Counters, flags and the quant stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skew_cnt_q <= '0;
      len_cnt_q  <= '0;
      sat_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      q_vld_q    <= 1'b0;
      q_dat_q    <= '0;
    end else begin
      skew_cnt_q <= skew_cnt_d;
      len_cnt_q  <= len_cnt_d;
      sat_cnt_q  <= sat_cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      q_vld_q    <= q_vld_d;
      q_dat_q    <= q_dat_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign sat_cnt_o = sat_cnt_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: directed tiles, expected words queued at start, popped by a monitor.
// Cycle k counts from the cycle in which start_i is high (cycle 0).
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pe_col_drain;
  import pe_drain_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_BW-1:0] len_i = '0;
  logic [CNT_BW-1:0] skew_i = '0;
  logic [ACC_BW-1:0] acc_i = '0;
  logic              busy_o, done_o, ovf_o;
  logic [CNT_BW-1:0] sat_cnt_o;

  pe_col_drain_if dif ();

  pe_col_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .len_i     (len_i),
    .skew_i    (skew_i),
    .acc_i     (acc_i),
    .dout_if   (dif),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_cnt_o (sat_cnt_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic [31:0] acc_v[16];
  logic [15:0] exp_v[16];
  int          pop_cnt = 0;
  int          last_pop_cyc = 0;
  int          first_vld_cyc = -1;
  int          start_cyc = 0;
  int          dcyc;

  // Scoreboard monitor: every accepted word is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && dif.dout_valid_o) begin
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (dif.dout_ready_i) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL dout_unexpected: got %h, no word expected", dif.dout_o);
        end else begin
          exp_w = exp_q.pop_front();
          if (dif.dout_o !== exp_w) begin
            fails++;
            $display("FAIL dout: got %h want %h", dif.dout_o, exp_w);
          end
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one tile; rdy_cyc raises ready in that cycle, glitch_cyc pulses a start that must be ignored.
  task automatic run_tile(input int skew, input int len, input int n_exp,
                          input int rdy_cyc, input int glitch_cyc);
    int ncyc;
    first_vld_cyc = -1;
    pop_cnt = 0;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(exp_v[i]);
    start_i = 1'b1;
    skew_i  = CNT_BW'(skew);
    len_i   = CNT_BW'(len);
    tick();
    start_cyc = cyc;
    start_i = 1'b0;
    check("clear_on_start_sat", sat_cnt_o, 0);
    check("clear_on_start_ovf", ovf_o, 0);
    check("busy_after_start", busy_o, 1);
    ncyc = (len == 0) ? 0 : skew + len;
    for (int c = 1; c <= ncyc; c++) begin
      acc_i = (c > skew) ? acc_v[c-skew-1] : 32'h5A5A_5A5A;
      if (c == rdy_cyc) dif.dout_ready_i = 1'b1;
      if (c == glitch_cyc) begin
        start_i = 1'b1;
        len_i   = CNT_BW'(1);
        skew_i  = '0;
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    start_i = 1'b0;
    acc_i   = 32'h7FFF_0000;
  endtask

  // Wait (bounded) for done_o and check the end-of-tile state.
  task automatic end_tile(input int want_pops, input int want_sat, input int want_ovf,
                          output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done_o within 100 cycles, want a pulse");
    end
    if (want_pops > 0) check("done_after_last_pop", done_cyc - last_pop_cyc, 1);
    check("pop_count", pop_cnt, want_pops);
    check("sat_cnt", sat_cnt_o, want_sat);
    check("ovf", ovf_o, want_ovf);
    check("exp_queue_left", exp_q.size(), 0);
    tick();
    check("done_is_pulse", done_o, 0);
    check("idle_after_done", busy_o, 0);
  endtask

  task automatic load_ramp(input int n);
    for (int k = 0; k < n; k++) begin
      acc_v[k] = 32'((k + 1) * 128);
      exp_v[k] = 16'(k + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dif.dout_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_valid", dif.dout_valid_o, 0);
    check("rst_dout", dif.dout_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sat", sat_cnt_o, 0);
    check("rst_ovf", ovf_o, 0);
    rst_n = 1'b1;
    tick();

    // Basic tile: skew 2, len 4, values 1..4, first valid in cycle 5.
    dif.dout_ready_i = 1'b1;
    load_ramp(4);
    run_tile(2, 4, 4, 0, 0);
    end_tile(4, 0, 0, dcyc);
    check("first_valid_cycle", first_vld_cyc - start_cyc + 1, 5);

    // Rounding cases.
    acc_v[0] = 32'd448;       exp_v[0] = 16'h0004;
    acc_v[1] = -32'sd448;     exp_v[1] = 16'hFFFD;
    acc_v[2] = 32'd64;        exp_v[2] = 16'h0001;
    acc_v[3] = 32'd63;        exp_v[3] = 16'h0000;
    run_tile(0, 4, 4, 0, 0);
    end_tile(4, 0, 0, dcyc);

    // Saturation cases.
    acc_v[0] = 32'h0010_0000; exp_v[0] = 16'h0FFF;
    acc_v[1] = 32'hFFF0_0000; exp_v[1] = 16'hF000;
    acc_v[2] = 32'h7FFF_FFFF; exp_v[2] = 16'h0FFF;
    run_tile(1, 3, 3, 0, 0);
    end_tile(3, 3, 0, dcyc);

    // Backpressure: 12 samples into 8 entries, sample 8 saturates, last 4 dropped.
    dif.dout_ready_i = 1'b0;
    load_ramp(12);
    acc_v[7] = 32'h0010_0000;
    exp_v[7] = 16'h0FFF;
    run_tile(0, 12, 8, 0, 0);
    repeat (3) tick();
    check("bp_ovf", ovf_o, 1);
    check("bp_valid_held", dif.dout_valid_o, 1);
    check("bp_busy", busy_o, 1);
    check("bp_no_done", done_o, 0);
    dif.dout_ready_i = 1'b1;
    end_tile(8, 1, 1, dcyc);

    // Full FIFO with a same-cycle pop: ready rises in cycle 10 when all 8 entries are occupied.
    dif.dout_ready_i = 1'b0;
    load_ramp(12);
    run_tile(0, 12, 12, 10, 0);
    end_tile(12, 0, 0, dcyc);

    // Empty tile: len 0 ignores skew and completes in cycle 2.
    run_tile(3, 0, 0, 0, 0);
    end_tile(0, 0, 0, dcyc);
    check("len0_done_cycle", dcyc - start_cyc + 1, 2);

    // Reset during CAPTURE after three samples.
    dif.dout_ready_i = 1'b0;
    start_i = 1'b1;
    skew_i  = '0;
    len_i   = CNT_BW'(6);
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      acc_i = 32'(c * 128);
      tick();
    end
    check("pre_rst_valid", dif.dout_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", dif.dout_valid_o, 0);
    check("mid_rst_dout", dif.dout_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_sat", sat_cnt_o, 0);
    check("mid_rst_ovf", ovf_o, 0);
    tick();
    rst_n = 1'b1;
    dcyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o || dif.dout_valid_o) dcyc++;
    end
    check("no_done_after_abort", dcyc, 0);
    tick();

    // Normal tile after the abort, with a start pulse in CAPTURE that must be ignored.
    dif.dout_ready_i = 1'b1;
    load_ramp(4);
    run_tile(2, 4, 4, 0, 4);
    end_tile(4, 0, 0, dcyc);
    check("first_valid_cycle_again", first_vld_cyc - start_cyc + 1, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
